// File: rtl/sram_req_ctrl.sv
// ---------------------------------------------------------------------------
// sram_req_ctrl
//
// Valid/ready request front-end for a single-port SRAM with a 1-cycle
// registered read port. Requests drive the SRAM pins combinationally in the
// accept cycle. Read data is captured the following cycle into a small
// in-order response FIFO so the consumer may stall without losing data.
// Read responses are credit-limited: a request is only accepted while
// (buffered responses + access in flight) < RSP_DEPTH, so the FIFO can never
// overflow.
//
// Optional feature macro: SRAM_CTRL_WR_ACK_EN
//   When defined, writes also take a credit and return a response whose
//   data is zero, keeping strict one-response-per-request ordering.
//
// Ports:
//   clk        in   single clock, all state updates on posedge
//   rst        in   synchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  controller can accept a request this cycle
//   req_we     in   1 = write, 0 = read
//   req_addr   in   word address
//   req_wdata  in   write data
//   rsp_valid  out  response FIFO head valid
//   rsp_ready  in   consumer takes the head
//   rsp_rdata  out  response data (zero while no response is held)
//   sram_cs    out  SRAM chip select
//   sram_we    out  SRAM write enable
//   sram_ad    out  SRAM address
//   sram_din   out  SRAM write data
//   sram_dout  in   SRAM read data (valid the cycle after a read)
// ---------------------------------------------------------------------------
module sram_req_ctrl #(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 32,
    parameter int DEPTH_LOG = $clog2(DEPTH),
    parameter int RSP_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [DEPTH_LOG-1:0] req_addr,
    input  logic [WIDTH-1:0]     req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_rdata,
    output logic                 sram_cs,
    output logic                 sram_we,
    output logic [DEPTH_LOG-1:0] sram_ad,
    output logic [WIDTH-1:0]     sram_din,
    input  logic [WIDTH-1:0]     sram_dout
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = (RSP_DEPTH > 2) ? $clog2(RSP_DEPTH) : 1;

    localparam logic [CNT_W:0]   CREDITS  = (CNT_W + 1)'(RSP_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);

    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic             r_inflight;
    logic [WIDTH-1:0] r_fifo [RSP_DEPTH];

    logic             w_accept;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_pushData;
    logic [CNT_W:0]   w_used;

    // Pointer advance with explicit wrap, since RSP_DEPTH need not be a
    // power of two.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Credits: every access that will produce a response occupies a slot
    // from acceptance until it is popped. Only registers feed this (plus the
    // reset gate), so there is no combinational path from rsp_ready or
    // req_valid into req_ready.
    assign w_used    = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
    assign req_ready = ~rst & (w_used < CREDITS);
    assign w_accept  = req_valid & req_ready;

    // SRAM pins follow the request directly; the SRAM itself registers the
    // access at the accept edge, so no extra issue cycle is needed.
    assign sram_cs  = w_accept;
    assign sram_we  = w_accept & req_we;
    assign sram_ad  = req_addr;
    assign sram_din = req_wdata;

`ifdef SRAM_CTRL_WR_ACK_EN
    logic r_inflightWr;

    // Writes are acknowledged too: they occupy a credit and push a zero
    // response through the same pipeline slot as a read.
    assign w_issue    = w_accept;
    assign w_pushData = r_inflightWr ? '0 : sram_dout;

    // Remembers whether the in-flight access was a write, so the push
    // stage knows to ignore the (stale) SRAM output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflightWr <= 1'b0;
        end else begin
            r_inflightWr <= w_accept & req_we;
        end
    end
`else
    // Only reads produce responses; writes complete silently in the SRAM.
    assign w_issue    = w_accept & ~req_we;
    assign w_pushData = sram_dout;
`endif

    // sram_dout is only meaningful the cycle after a read accept, which is
    // exactly when r_inflight is set.
    assign w_push    = r_inflight;
    assign rsp_valid = (r_count != '0);
    assign w_pop     = rsp_valid & rsp_ready;

    // Head data is gated so the output reads zero whenever nothing is held,
    // including right after reset when the storage is not cleared.
    assign rsp_rdata = rsp_valid ? r_fifo[r_head] : '0;

    // Control state: in-flight flag, occupancy and pointers. Reset discards
    // any in-flight read and every buffered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_push) begin
                r_tail <= nextPtr(r_tail);
            end
            if (w_pop) begin
                r_head <= nextPtr(r_head);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Response storage is left unreset; the count alone decides what is
    // valid, which lets this map onto plain register-file storage.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_tail] <= w_pushData;
        end
    end

endmodule
